oam_dma_engine: RTL

- Bus master that performs the OAM DMA copy into LCD RAM.
- Snoops CPU writes to the DMA register (0xFF46) and reads LENGTH bytes from system memory at {reg, 8'h00}.
- Writes those bytes through the LCD RAM active-low WE/RE bus interface, starting at DST_BASE.
- Sits directly upstream of the LCD RAM port. O_BUSY is used by the arbiter to lock the CPU out of the bus.

---
 rtl/oam_dma_engine.sv | 121 ++++++++++++
 1 files changed

// File: rtl/oam_dma_engine.sv
// OAM DMA bus master: snoops CPU writes to the DMA register and copies LENGTH
// bytes from {reg,8'h00} into LCD RAM through the active-low strobe interface.
module oam_dma_engine #(
  parameter logic [15:0] TRIG_ADDR = 16'hFF46,
  parameter logic [15:0] DST_BASE  = 16'hFE00,
  parameter int          LENGTH    = 160,
  parameter int          READ_LAT  = 2
) (
  input  logic        I_MEM_CLK,
  input  logic        I_RESET,
  input  logic [15:0] I_CPU_ADDR,
  input  logic [7:0]  I_CPU_DATA,
  input  logic        I_CPU_WE_L,
  output logic [7:0]  O_REG_DATA,
  output logic [15:0] O_SRC_ADDR,
  output logic        O_SRC_RE_L,
  input  logic [7:0]  I_SRC_DATA,
  output logic [15:0] O_DST_ADDR,
  output logic [7:0]  O_DST_DATA,
  output logic        O_DST_WE_L,
  output logic        O_BUSY,
  output logic        O_DONE
);

  localparam int             WW        = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [7:0]     LAST_IDX  = 8'(LENGTH - 1);
  localparam logic [WW-1:0]  LAST_WAIT = WW'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, GAP} state_t;

  state_t         state, state_d;
  logic [7:0]     idx, idx_d, idx_inc;
  logic [WW-1:0]  wait_cnt, wait_d;
  logic [7:0]     src_hi, src_hi_d, mapped_hi;
  logic [7:0]     reg_data_d, dst_data_d;
  logic [15:0]    src_addr_d, dst_addr_d;
  logic           done_d, we_l_q, trigger;

  // Falling-edge detect so a strobe held low starts only one transfer.
  assign trigger   = !I_CPU_WE_L && we_l_q && (I_CPU_ADDR == TRIG_ADDR);
  // Echo RAM pages E0..FF alias C0..DF.
  assign mapped_hi = (I_CPU_DATA >= 8'hE0) ? (I_CPU_DATA - 8'h20) : I_CPU_DATA;
  assign idx_inc   = idx + 8'd1;

  assign O_SRC_RE_L = (state != READ);
  assign O_DST_WE_L = (state != WRITE);
  assign O_BUSY     = (state != IDLE);

  always_comb begin
    state_d    = state;
    idx_d      = idx;
    wait_d     = wait_cnt;
    src_hi_d   = src_hi;
    reg_data_d = O_REG_DATA;
    src_addr_d = O_SRC_ADDR;
    dst_addr_d = O_DST_ADDR;
    dst_data_d = O_DST_DATA;
    done_d     = 1'b0;
    if (trigger) begin
      // Retrigger wins over everything, including completion in the last GAP.
      state_d    = READ;
      idx_d      = 8'd0;
      wait_d     = '0;
      src_hi_d   = mapped_hi;
      reg_data_d = I_CPU_DATA;
      src_addr_d = {mapped_hi, 8'h00};
    end else begin
      case (state)
        READ: begin
          if (wait_cnt == LAST_WAIT) begin
            state_d    = WRITE;
            dst_addr_d = DST_BASE + {8'h00, idx};
            dst_data_d = I_SRC_DATA;
          end else begin
            wait_d = wait_cnt + WW'(1);
          end
        end
        WRITE: state_d = GAP;
        GAP: begin
          if (idx == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d    = READ;
            idx_d      = idx_inc;
            wait_d     = '0;
            src_addr_d = {src_hi, 8'h00} + {8'h00, idx_inc};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge I_MEM_CLK) begin
    if (I_RESET) begin
      state      <= IDLE;
      idx        <= 8'd0;
      wait_cnt   <= '0;
      src_hi     <= 8'd0;
      we_l_q     <= 1'b1;
      O_REG_DATA <= 8'd0;
      O_SRC_ADDR <= 16'd0;
      O_DST_ADDR <= 16'd0;
      O_DST_DATA <= 8'd0;
      O_DONE     <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      wait_cnt   <= wait_d;
      src_hi     <= src_hi_d;
      we_l_q     <= I_CPU_WE_L;
      O_REG_DATA <= reg_data_d;
      O_SRC_ADDR <= src_addr_d;
      O_DST_ADDR <= dst_addr_d;
      O_DST_DATA <= dst_data_d;
      O_DONE     <= done_d;
    end
  end

endmodule
